// File: rtl/prbs22_checker.sv
// Receive-side checker for the x^22 + x^21 + 1 PRBS stream: self-synchronises,
// then flywheels a local LFSR and reports lock, per-bit errors and an error count.
module prbs22_checker #(
  parameter int LOCK_CNT    = 32,
  parameter int WINDOW      = 64,
  parameter int LOSS_THRESH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sh_en,
  input  logic        din,
  input  logic        clr_cnt,
  output logic        locked,
  output logic        err,
  output logic [15:0] err_count,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [7:0] GOOD_LAST   = 8'(LOCK_CNT - 1);
  localparam logic [9:0] WIN_LAST    = 10'(WINDOW - 1);
  localparam logic [9:0] THRESH_LAST = 10'(LOSS_THRESH - 1);

  state_t      cur, cur_nx;
  logic [21:0] s, s_nx;
  logic [4:0]  fill, fill_nx;
  logic [7:0]  good, good_nx;
  logic [9:0]  win_bits, win_bits_nx;
  logic [9:0]  win_errs, win_errs_nx;
  logic [15:0] cnt_nx;
  logic        err_nx;
  logic        pred;
  logic        miss;
  logic [21:0] s_fill;

  assign pred   = s[21] ^ s[20];
  assign miss   = din ^ pred;
  assign s_fill = {s[20:0], din};

  always_ff @(posedge clk) begin
    if (rst) begin
      cur       <= HUNT;
      s         <= '0;
      fill      <= '0;
      good      <= '0;
      win_bits  <= '0;
      win_errs  <= '0;
      err       <= 1'b0;
      err_count <= '0;
    end else begin
      cur       <= cur_nx;
      s         <= s_nx;
      fill      <= fill_nx;
      good      <= good_nx;
      win_bits  <= win_bits_nx;
      win_errs  <= win_errs_nx;
      err       <= err_nx;
      err_count <= cnt_nx;
    end
  end

  always_comb begin
    cur_nx      = cur;
    s_nx        = s;
    fill_nx     = fill;
    good_nx     = good;
    win_bits_nx = win_bits;
    win_errs_nx = win_errs;
    err_nx      = 1'b0;
    cnt_nx      = err_count;

    if (sh_en) begin
      case (cur)
        HUNT: begin
          s_nx = s_fill;
          if (fill == 5'd21) begin
            fill_nx = '0;
            // an all-zero fill is the LFSR lock-up state; keep hunting
            if (s_fill != '0) cur_nx = VERIFY;
          end else begin
            fill_nx = fill + 5'd1;
          end
        end
        VERIFY: begin
          if (miss) begin
            err_nx  = 1'b1;
            fill_nx = '0;
            good_nx = '0;
            cur_nx  = HUNT;
          end else begin
            s_nx = {s[20:0], pred};
            if (good == GOOD_LAST) begin
              good_nx = '0;
              cur_nx  = LOCKED;
            end else begin
              good_nx = good + 8'd1;
            end
          end
        end
        LOCKED: begin
          s_nx = {s[20:0], pred};
          if (miss) begin
            err_nx = 1'b1;
            if (err_count != 16'hFFFF) cnt_nx = err_count + 16'd1;
          end
          // loss takes priority over the window rollover on the same bit
          if (miss && win_errs == THRESH_LAST) begin
            cur_nx      = HUNT;
            win_bits_nx = '0;
            win_errs_nx = '0;
            fill_nx     = '0;
            good_nx     = '0;
          end else if (win_bits == WIN_LAST) begin
            win_bits_nx = '0;
            win_errs_nx = '0;
          end else begin
            win_bits_nx = win_bits + 10'd1;
            win_errs_nx = win_errs + {9'd0, miss};
          end
        end
        default: cur_nx = HUNT;
      endcase
    end

    if (clr_cnt) cnt_nx = '0;
  end

  assign locked = (cur == LOCKED);
  assign state  = cur;

endmodule

// File: doc/prbs22_checker.md
# prbs22_checker

Serial receive-side checker for the 22-bit PRBS stream produced by the team's LFSR generator. Polynomial is x^22 + x^21 + 1. The block self-synchronises to the incoming bitstream, then verifies every subsequent bit against a locally regenerated sequence. It reports lock status, per-bit error pulses and a saturating error count. It sits at the far end of the serial link, fed by the generator's MSB output and its shift-enable, and closes the loop for link BER tests.

## Interface
- LOCK_CNT, 32: consecutive correct predicted bits required in VERIFY before declaring lock (1..255).
- WINDOW, 64: valid-bit window length used for loss-of-lock evaluation in LOCKED (2..1023).
- LOSS_THRESH, 8: errors within one window that force return to HUNT (1..WINDOW).
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- sh_en  in  1  din qualifier; a bit is consumed only on cycles with sh_en=1.
- din  in  1  received serial bit (generator MSB).
- clr_cnt  in  1  synchronous clear of err_count; does not affect state.
- locked  out  1  high while state is LOCKED.
- err  out  1  one-cycle pulse, registered; high when the previous consumed bit mismatched in VERIFY or LOCKED.
- err_count  out  16  saturating count of mismatches seen in LOCKED.
- state  out  2  encoding: HUNT=0, VERIFY=1, LOCKED=2.

## Operation
- Internal registers:
  - s[21:0] is the local LFSR.
  - Predicted bit: p = s[21] ^ s[20].
  - Shift: s <= {s[20:0], x}, where x is the bit shifted in.
- HUNT:
  - Each consumed bit shifts din into s; a fill counter increments.
  - After 22 bits, if s (including the 22nd bit) is non-zero, go to VERIFY.
  - If s is all-zero, clear the fill counter and stay in HUNT, so a stuck-low line never locks.
- VERIFY:
  - Each consumed bit compares din with p; s shifts in p (flywheel, no error multiplication).
  - On a match, the good counter increments.
  - On reaching LOCK_CNT, go to LOCKED.
  - On a mismatch, pulse err, clear the fill and good counters, and return to HUNT.
  - The mismatching bit is discarded; it is not used as the first fill bit.
- LOCKED:
  - Each consumed bit compares din with p; s shifts in p.
  - On a mismatch, pulse err, increment err_count (saturating at 0xFFFF) and increment the window error counter.
  - The window bit counter increments per consumed bit. At WINDOW bits, both window counters clear.
  - When window errors reach LOSS_THRESH, go to HUNT immediately. Clear all counters except err_count.
- Error counting:
  - Errors in VERIFY pulse err but do not touch err_count.
  - clr_cnt has priority over an increment in the same cycle; the result is 0.
- Gaps: cycles with sh_en=0 change no register; err is 0 on those cycles.

## Timing
- Reset (rst=1 at an edge):
  - state=HUNT, locked=0, err=0, err_count=0, s=0.
  - All counters are 0.
  - Applies from any state, including mid-lock.
- Outputs are registered. locked, state and err reflect the bit consumed at the previous edge.
- Lock latency from a clean stream is 22 + LOCK_CNT consumed bits; the default is 54.
  - locked rises after the edge that consumes bit 54.
- Loss latency: locked falls after the edge consuming the LOSS_THRESH-th error in a window.
- Window boundary, simultaneous events:
  - An error on the WINDOW-th bit counts in the closing window.
  - If that error reaches LOSS_THRESH, loss wins over the window clear.
- rst held high ignores sh_en, din and clr_cnt.

## Test plan
- Clean lock:
  - Stimulus: rst for 2 cycles, then a generator stream from seed 22'h3FFFFF with sh_en=1 continuously.
  - Required: state 0→1 after bit 22; locked=1 after bit 54; err never asserts; err_count=0 after 10,000 bits.
- Single error:
  - Stimulus: in LOCKED, invert one din bit.
  - Required: exactly one err pulse on the next cycle; err_count=1; locked stays 1; the following bits are error-free.
- Loss of lock:
  - Stimulus: in LOCKED, invert 8 bits within one 64-bit window.
  - Required: locked falls after the 8th error; state=0; the stream then relocks after 54 further bits; err_count=8.
- Stuck-zero line:
  - Stimulus: din=0 with sh_en=1 for 500 cycles.
  - Required: state stays 0; locked=0; err=0 throughout.
- Gaps and clear:
  - Stimulus: a clean stream with sh_en deasserted every third cycle.
  - Required: lock after 54 consumed bits, not 54 cycles.
  - Stimulus: assert clr_cnt in the same cycle as an error consumption.
  - Required: err_count=0.
- Reset mid-operation:
  - Stimulus: in LOCKED with err_count=5, assert rst for 1 cycle.
  - Required: next cycle locked=0, state=0, err_count=0, err=0.
